// File: rtl/bp_cce_mode_sequencer_pkg.sv
// Shared types for the CCE mode sequencer slice: mode enum, config bus,
// and the LCE command header used for sync broadcasts.
package bp_cce_mode_sequencer_pkg;

    localparam int num_lce_gp      = 4;
    localparam int lce_id_width_gp = 4;
    localparam int cce_id_width_gp = 4;
    localparam int paddr_width_gp  = 40;
    localparam int dword_width_gp  = 64;

    typedef enum logic {
        e_cce_mode_uncached = 1'b0,
        e_cce_mode_normal   = 1'b1
    } bp_cce_mode_e;

    typedef enum logic [3:0] {
        e_bedrock_cmd_sync      = 4'b0000,
        e_bedrock_cmd_set_clear = 4'b0001,
        e_bedrock_cmd_inv       = 4'b0010,
        e_bedrock_cmd_st        = 4'b0011,
        e_bedrock_cmd_data      = 4'b0100
    } bp_bedrock_cmd_type_e;

    typedef struct packed {
        logic                       freeze;
        logic [cce_id_width_gp-1:0] core_id;
        logic [cce_id_width_gp-1:0] cce_id;
        bp_cce_mode_e               cce_mode;
    } bp_cfg_bus_s;

    typedef struct packed {
        bp_bedrock_cmd_type_e cmd;
    } bp_bedrock_msg_type_s;

    typedef struct packed {
        logic [lce_id_width_gp-1:0] dst_id;
        logic [cce_id_width_gp-1:0] src_id;
        logic [2:0]                 way_id;
        logic [2:0]                 state;
    } bp_bedrock_lce_cmd_payload_s;

    typedef struct packed {
        bp_bedrock_lce_cmd_payload_s payload;
        logic [2:0]                  size;
        logic [paddr_width_gp-1:0]   addr;
        logic [3:0]                  subop;
        bp_bedrock_msg_type_s        msg_type;
    } bp_bedrock_lce_cmd_header_s;

    localparam int cfg_bus_width_gp            = $bits(bp_cfg_bus_s);
    localparam int lce_cmd_msg_header_width_gp = $bits(bp_bedrock_lce_cmd_header_s);

endpackage

// File: rtl/bp_cce_mode_sequencer_sync_tracker.sv
// Per-LCE pending-sync bitmap plus outstanding counter; flags acks that
// match no pending sync.
module bp_cce_sync_tracker
    import bp_cce_mode_sequencer_pkg::*;
#(
    parameter int num_lce_p         = num_lce_gp,
    parameter int max_outstanding_p = num_lce_p,
    parameter int id_width_p        = lce_id_width_gp,
    localparam int lg_num_lce_lp    = (num_lce_p > 1) ? $clog2(num_lce_p) : 1,
    localparam int cnt_width_lp     = $clog2(max_outstanding_p + 1)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     set_v_i,
    input  logic [lg_num_lce_lp-1:0] set_id_i,
    input  logic                     ack_v_i,
    input  logic [id_width_p-1:0]    ack_id_i,
    output logic                     all_clear_o,
    output logic                     window_full_o,
    output logic                     unexpected_o
);

    logic [num_lce_p-1:0]    pending_r;
    logic [cnt_width_lp-1:0] count_r;
    logic [lg_num_lce_lp-1:0] ack_idx;
    logic                    ack_in_range;
    logic                    ack_hit;

    assign ack_idx      = ack_id_i[lg_num_lce_lp-1:0];
    assign ack_in_range = (int'(ack_id_i) < num_lce_p);
    assign ack_hit      = ack_v_i & ack_in_range & pending_r[ack_idx];
    assign unexpected_o = ack_v_i & ~ack_hit;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pending_r <= '0;
            count_r   <= '0;
        end else begin
            // The acked id never equals the id being sent, so both updates may land together
            if (set_v_i) pending_r[set_id_i] <= 1'b1;
            if (ack_hit) pending_r[ack_idx]  <= 1'b0;
            count_r <= count_r + cnt_width_lp'(set_v_i) - cnt_width_lp'(ack_hit);
        end
    end

    assign all_clear_o   = ~|pending_r;
    assign window_full_o = (count_r >= cnt_width_lp'(max_outstanding_p));

endmodule

// File: rtl/bp_cce_mode_sequencer.sv
// Global CCE mode controller: drains the pipes on a mode request, broadcasts
// syncs to every LCE on uncached->normal, and commits once all acks return.
module bp_cce_mode_sequencer
    import bp_cce_mode_sequencer_pkg::*;
#(
    parameter int num_lce_p         = num_lce_gp,
    parameter int max_outstanding_p = num_lce_p,
    parameter int lce_data_width_p  = dword_width_gp,
    localparam int lce_id_width_p   = lce_id_width_gp,
    localparam int cce_id_width_p   = cce_id_width_gp,
    localparam int lg_num_lce_lp    = (num_lce_p > 1) ? $clog2(num_lce_p) : 1
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic [cfg_bus_width_gp-1:0]            cfg_bus_i,
    output logic [lce_cmd_msg_header_width_gp-1:0] lce_cmd_header_o,
    output logic                                   lce_cmd_header_v_o,
    input  logic                                   lce_cmd_header_ready_and_i,
    output logic                                   lce_cmd_has_data_o,
    output logic [lce_data_width_p-1:0]            lce_cmd_data_o,
    output logic                                   lce_cmd_data_v_o,
    output logic                                   lce_cmd_last_o,
    input  logic                                   lce_cmd_data_ready_and_i,
    input  logic                                   sync_ack_v_i,
    input  logic [lce_id_width_p-1:0]              sync_ack_lce_id_i,
    output logic                                   cce_mode_o,
    output logic [cce_id_width_p-1:0]              cce_id_o,
    output logic                                   drain_then_stall_o,
    output logic                                   busy_o,
    output logic                                   sync_err_o,
    input  logic                                   req_empty_i,
    input  logic                                   uc_pipe_empty_i,
    input  logic                                   coh_pipe_empty_i,
    input  logic                                   mem_credits_full_i
);

    typedef enum logic [1:0] {
        e_ready,
        e_drain,
        e_send_sync,
        e_wait_ack
    } state_e;

    state_e                     state_r, state_n;
    bp_cce_mode_e               mode_r, target_r;
    logic [lg_num_lce_lp-1:0]   dst_r, dst_n;
    logic                       drain_r, err_r;
    logic                       mode_en, target_en, drain_set, drain_clear;
    logic                       drain_complete, send_hs;
    logic                       all_clear, window_full, unexpected;
    bp_cfg_bus_s                cfg_bus;
    bp_bedrock_lce_cmd_header_s header;

    assign cfg_bus        = cfg_bus_i;
    assign drain_complete = drain_r & req_empty_i & uc_pipe_empty_i
                          & coh_pipe_empty_i & mem_credits_full_i;
    assign send_hs        = lce_cmd_header_v_o & lce_cmd_header_ready_and_i;

    bp_cce_sync_tracker #(
        .num_lce_p         (num_lce_p),
        .max_outstanding_p (max_outstanding_p),
        .id_width_p        (lce_id_width_p)
    ) tracker (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .set_v_i       (send_hs),
        .set_id_i      (dst_r),
        .ack_v_i       (sync_ack_v_i),
        .ack_id_i      (sync_ack_lce_id_i),
        .all_clear_o   (all_clear),
        .window_full_o (window_full),
        .unexpected_o  (unexpected)
    );

    always_comb begin
        state_n            = state_r;
        dst_n              = dst_r;
        mode_en            = 1'b0;
        target_en          = 1'b0;
        drain_set          = 1'b0;
        drain_clear        = 1'b0;
        lce_cmd_header_v_o = 1'b0;
        case (state_r)
            e_ready: begin
                if (cfg_bus.cce_mode != mode_r) begin
                    target_en = 1'b1;
                    drain_set = 1'b1;
                    state_n   = e_drain;
                end
            end
            e_drain: begin
                if (drain_complete) begin
                    if (target_r == e_cce_mode_uncached) begin
                        mode_en     = 1'b1;
                        drain_clear = 1'b1;
                        state_n     = e_ready;
                    end else begin
                        dst_n   = '0;
                        state_n = e_send_sync;
                    end
                end
            end
            e_send_sync: begin
                lce_cmd_header_v_o = ~window_full;
                if (send_hs) begin
                    dst_n = dst_r + lg_num_lce_lp'(1);
                    if (dst_r == lg_num_lce_lp'(num_lce_p - 1)) state_n = e_wait_ack;
                end
            end
            e_wait_ack: begin
                if (all_clear & ~sync_ack_v_i) begin
                    mode_en     = 1'b1;
                    drain_clear = 1'b1;
                    state_n     = e_ready;
                end
            end
            default: state_n = e_ready;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r  <= e_ready;
            dst_r    <= '0;
            mode_r   <= e_cce_mode_uncached;
            target_r <= e_cce_mode_uncached;
            drain_r  <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            state_r <= state_n;
            dst_r   <= dst_n;
            if (mode_en)   mode_r   <= target_r;
            if (target_en) target_r <= cfg_bus.cce_mode;
            if (drain_set)        drain_r <= 1'b1;
            else if (drain_clear) drain_r <= 1'b0;
            if (unexpected) err_r <= 1'b1;
        end
    end

    // Header depends only on dst_r and static config, so it holds steady under backpressure
    always_comb begin
        header                = '0;
        header.msg_type.cmd   = e_bedrock_cmd_sync;
        header.payload.dst_id = lce_id_width_p'(dst_r);
        header.payload.src_id = cfg_bus.cce_id;
    end

    assign lce_cmd_header_o   = header;
    assign lce_cmd_has_data_o = 1'b0;
    assign lce_cmd_data_v_o   = 1'b0;
    assign lce_cmd_data_o     = '0;
    assign lce_cmd_last_o     = 1'b0;
    assign cce_mode_o         = mode_r;
    assign cce_id_o           = cfg_bus.cce_id;
    assign drain_then_stall_o = drain_r;
    assign busy_o             = (state_r != e_ready);
    assign sync_err_o         = err_r;

    logic unused;
    assign unused = &{lce_cmd_data_ready_and_i, cfg_bus.freeze, cfg_bus.core_id};

endmodule

// File: tb/tb_bp_cce_mode_sequencer.sv
// Directed bench for bp_cce_mode_sequencer: cycle table for the basic
// transitions plus hand-written multi-cycle sequences.
module tb_bp_cce_mode_sequencer;
    import bp_cce_mode_sequencer_pkg::*;

    localparam int HW = lce_cmd_msg_header_width_gp;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // dut: max_outstanding 4
    bp_cfg_bus_s      cfg;
    logic             ready, ack_v, coh_empty;
    logic [3:0]       ack_id;
    logic [HW-1:0]    hdr;
    logic             v, has_data, data_v, last, mode, drain, busy, err;
    logic [63:0]      data;
    logic [3:0]       cce_id;

    // dut1: max_outstanding 1
    bp_cfg_bus_s      cfg1;
    logic             ready1, ack1_v;
    logic [3:0]       ack1_id;
    logic [HW-1:0]    hdr1;
    logic             v1, has_data1, data_v1, last1, mode1, drain1, busy1, err1;
    logic [63:0]      data1;
    logic [3:0]       cce_id1;

    bp_cce_mode_sequencer #(.num_lce_p(4), .max_outstanding_p(4), .lce_data_width_p(64)) dut (
        .clk_i(clk), .reset_i(reset), .cfg_bus_i(cfg),
        .lce_cmd_header_o(hdr), .lce_cmd_header_v_o(v), .lce_cmd_header_ready_and_i(ready),
        .lce_cmd_has_data_o(has_data), .lce_cmd_data_o(data), .lce_cmd_data_v_o(data_v),
        .lce_cmd_last_o(last), .lce_cmd_data_ready_and_i(1'b1),
        .sync_ack_v_i(ack_v), .sync_ack_lce_id_i(ack_id),
        .cce_mode_o(mode), .cce_id_o(cce_id), .drain_then_stall_o(drain), .busy_o(busy),
        .sync_err_o(err), .req_empty_i(1'b1), .uc_pipe_empty_i(1'b1),
        .coh_pipe_empty_i(coh_empty), .mem_credits_full_i(1'b1)
    );

    bp_cce_mode_sequencer #(.num_lce_p(4), .max_outstanding_p(1), .lce_data_width_p(64)) dut1 (
        .clk_i(clk), .reset_i(reset), .cfg_bus_i(cfg1),
        .lce_cmd_header_o(hdr1), .lce_cmd_header_v_o(v1), .lce_cmd_header_ready_and_i(ready1),
        .lce_cmd_has_data_o(has_data1), .lce_cmd_data_o(data1), .lce_cmd_data_v_o(data_v1),
        .lce_cmd_last_o(last1), .lce_cmd_data_ready_and_i(1'b1),
        .sync_ack_v_i(ack1_v), .sync_ack_lce_id_i(ack1_id),
        .cce_mode_o(mode1), .cce_id_o(cce_id1), .drain_then_stall_o(drain1), .busy_o(busy1),
        .sync_err_o(err1), .req_empty_i(1'b1), .uc_pipe_empty_i(1'b1),
        .coh_pipe_empty_i(1'b1), .mem_credits_full_i(1'b1)
    );

    int checks = 0;
    int passes = 0;

    typedef struct {
        bp_cce_mode_e cfg_mode;
        logic         coh;
        logic         av;
        logic [3:0]   aid;
        logic         ev;
        int           edst;
        logic         em, ed, eb, ee;
    } vec_t;
    vec_t vecs[$];

    logic [3:0] ooo_ids [5] = '{4'd3, 4'd0, 4'd2, 4'd2, 4'd1};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [HW-1:0] exp_hdr(input int dst);
        bp_bedrock_lce_cmd_header_s h;
        h                = '0;
        h.msg_type.cmd   = e_bedrock_cmd_sync;
        h.payload.dst_id = 4'(dst);
        h.payload.src_id = 4'h5;
        return h;
    endfunction

    task automatic chk(input string name, input logic ev, em, ed, eb, ee);
        check(name, {v, mode, drain, busy, err}, {ev, em, ed, eb, ee});
    endtask

    task automatic chk1(input string name, input logic ev, em, ed, eb, ee);
        check(name, {v1, mode1, drain1, busy1, err1}, {ev, em, ed, eb, ee});
    endtask

    task automatic add(input bp_cce_mode_e cm, input logic coh, av, input logic [3:0] aid,
                       input logic ev, input int edst, input logic em, ed, eb, ee);
        vec_t r;
        r.cfg_mode = cm; r.coh = coh; r.av = av; r.aid = aid;
        r.ev = ev; r.edst = edst; r.em = em; r.ed = ed; r.eb = eb; r.ee = ee;
        vecs.push_back(r);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bp_cce_mode_e U, N;
        int sent, cyc;
        logic held, first_stall;
        logic [HW-1:0] saved;
        U = e_cce_mode_uncached;
        N = e_cce_mode_normal;

        cfg  = '0; cfg.cce_id  = 4'h5; cfg.core_id  = 4'h2;
        cfg1 = '0; cfg1.cce_id = 4'h5; cfg1.core_id = 4'h3;
        ready = 1'b1; ack_v = 1'b0; ack_id = '0; coh_empty = 1'b1;
        ready1 = 1'b1; ack1_v = 1'b0; ack1_id = '0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        chk("reset", 0, 0, 0, 0, 0);
        check("tied_outputs", {has_data, data_v, last, |data, cce_id}, {4'b0000, 4'h5});

        // cycle table: uncached->normal with 5-cycle ack latency, then normal->uncached
        add(N,1,0,0, 0,0, 0,0,0,0);
        add(N,1,0,0, 0,0, 0,1,1,0);
        for (int k = 0; k < 4; k++) add(N,1,0,0, 1,k, 0,1,1,0);
        add(N,1,0,0, 0,0, 0,1,1,0);
        for (int k = 0; k < 4; k++) add(N,1,1,4'(k), 0,0, 0,1,1,0);
        add(N,1,0,0, 0,0, 0,1,1,0);
        add(U,1,0,0, 0,0, 1,0,0,0);
        for (int k = 0; k < 10; k++) add(U,0,0,0, 0,0, 1,1,1,0);
        add(U,1,0,0, 0,0, 1,1,1,0);
        add(U,1,0,0, 0,0, 0,0,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            cfg.cce_mode = vecs[i].cfg_mode;
            coh_empty    = vecs[i].coh;
            ack_v        = vecs[i].av;
            ack_id       = vecs[i].aid;
            check($sformatf("vec%0d", i),
                  {v, mode, drain, busy, err, (v ? hdr : {HW{1'b0}})},
                  {vecs[i].ev, vecs[i].em, vecs[i].ed, vecs[i].eb, vecs[i].ee,
                   (vecs[i].ev ? exp_hdr(vecs[i].edst) : {HW{1'b0}})});
            tick();
        end
        ack_v = 1'b0; coh_empty = 1'b1;

        // single-window instance: one sync in flight at a time
        cfg1.cce_mode = N;
        chk1("w1_idle", 0, 0, 0, 0, 0);
        tick();
        chk1("w1_drain", 0, 0, 1, 1, 0);
        tick();
        for (int k = 0; k < 4; k++) begin
            chk1($sformatf("w1_send%0d", k), 1, 0, 1, 1, 0);
            check($sformatf("w1_hdr%0d", k), hdr1, exp_hdr(k));
            tick();
            chk1($sformatf("w1_full%0d", k), 0, 0, 1, 1, 0);
            tick();
            ack1_v = 1'b1; ack1_id = 4'(k);
            chk1($sformatf("w1_ackcyc%0d", k), 0, 0, 1, 1, 0);
            tick();
            ack1_v = 1'b0;
        end
        chk1("w1_clear", 0, 0, 1, 1, 0);
        tick();
        chk1("w1_commit", 0, 1, 0, 0, 0);

        // random ready stalls, out-of-order acks with a duplicate
        cfg.cce_mode = N;
        sent = 0; cyc = 0; held = 1'b0; first_stall = 1'b1; saved = '0;
        while (sent < 4 && cyc < 200) begin
            if (held) check($sformatf("hold%0d", cyc), {v, hdr}, {1'b1, saved});
            if (v) begin
                if (first_stall) ready = 1'b0;
                else ready = 1'($urandom_range(0, 1));
                first_stall = 1'b0;
                if (ready) begin
                    check($sformatf("ooo_hdr%0d", sent), hdr, exp_hdr(sent));
                    sent++;
                    held = 1'b0;
                end else begin
                    held  = 1'b1;
                    saved = hdr;
                end
            end else begin
                ready = 1'b0;
            end
            tick();
            cyc++;
        end
        check("ooo_sent_count", 128'(sent), 128'(4));
        ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ack_v = 1'b1; ack_id = ooo_ids[i];
            chk($sformatf("ooo_ack%0d", i), 0, 0, 1, 1, (i >= 4) ? 1'b1 : 1'b0);
            tick();
        end
        ack_v = 1'b0;
        chk("ooo_pre_commit", 0, 0, 1, 1, 1);
        tick();
        chk("ooo_commit", 0, 1, 0, 0, 1);

        // reset in the middle of a sync broadcast
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("reset2", 0, 0, 0, 0, 0);
        tick();
        tick();
        chk("rst_send0", 1, 0, 1, 1, 0);
        tick();
        reset = 1'b1; cfg.cce_mode = U;
        tick();
        reset = 1'b0;
        chk("rst_mid", 0, 0, 0, 0, 0);
        ack_v = 1'b1; ack_id = 4'd0;
        tick();
        ack_v = 1'b0;
        chk("rst_stale_ack", 0, 0, 0, 0, 1);

        // cfg flips back to uncached while syncs are going out
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cfg.cce_mode = N;
        chk("tog_start", 0, 0, 0, 0, 0);
        tick();
        tick();
        check("tog_hdr0", {v, hdr}, {1'b1, exp_hdr(0)});
        cfg.cce_mode = U;
        tick();
        ack_v = 1'b1; ack_id = 4'd0;
        check("tog_hdr1", {v, hdr}, {1'b1, exp_hdr(1)});
        tick();
        ack_id = 4'd1;
        tick();
        ack_id = 4'd2;
        check("tog_hdr3", {v, hdr}, {1'b1, exp_hdr(3)});
        tick();
        ack_id = 4'd3;
        chk("tog_wait", 0, 0, 1, 1, 0);
        tick();
        ack_v = 1'b0;
        chk("tog_clear", 0, 0, 1, 1, 0);
        tick();
        chk("tog_normal", 0, 1, 0, 0, 0);
        tick();
        chk("tog_drain2", 0, 1, 1, 1, 0);
        tick();
        chk("tog_uncached", 0, 0, 0, 0, 0);

        // out-of-range ack id
        ack_v = 1'b1; ack_id = 4'd7;
        tick();
        ack_v = 1'b0;
        chk("bad_id", 0, 0, 0, 0, 1);
        tick();
        tick();
        chk("bad_id_sticky", 0, 0, 0, 0, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
